// File: rtl/cnn_layer_accel_job_sequencer.sv
// Host-side job sequencer for one cnn_layer_accel_quad: queues descriptors, walks each job
// through the start/fetch/complete handshake, bridges fetch to DMA and traps hung jobs.
module cnn_layer_accel_job_sequencer #(
  parameter int C_DESC_DEPTH = 4,
  parameter int C_TIMEOUT    = 65535,
  parameter int C_CNT_W      = 16
) (
  input  logic               clk_if,
  input  logic               rst,
  input  logic               desc_valid,
  output logic               desc_ready,
  input  logic [127:0]       desc_data,
  output logic               job_start,
  input  logic               job_accept,
  output logic [127:0]       job_parameters,
  input  logic               job_fetch_request,
  output logic               job_fetch_ack,
  output logic               job_fetch_complete,
  input  logic               job_complete,
  output logic               job_complete_ack,
  output logic               dma_req,
  input  logic               dma_grant,
  input  logic               dma_done,
  input  logic               err_clear,
  output logic               busy,
  output logic               timeout_err,
  output logic [2:0]         err_state,
  output logic [C_CNT_W-1:0] jobs_done
);

  localparam int AW   = $clog2(C_DESC_DEPTH);
  localparam int WD_W = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    FETCH_WAIT = 3'd2,
    DMA_REQ    = 3'd3,
    DMA_WAIT   = 3'd4,
    RUN        = 3'd5,
    ERROR      = 3'd6
  } state_t;

  state_t               state_reg, state_next;
  logic [127:0]         fifo_mem [C_DESC_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic [127:0]         job_parameters_reg;
  logic [WD_W-1:0]      wd_cnt_reg, wd_cnt_next;
  logic [2:0]           err_state_reg;
  logic [C_CNT_W-1:0]   jobs_done_reg;
  logic                 fetch_ack_reg, fetch_complete_reg, complete_ack_reg;
  logic                 fifo_full, fifo_empty, push, pop;
  logic                 wd_active, wd_expired;

  assign fifo_full  = (count_reg == (AW+1)'(C_DESC_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = desc_valid && !fifo_full;
  // The cycle carrying job_complete_ack is skipped so the quad sees the ack before a new start.
  assign pop        = (state_reg == IDLE) && !fifo_empty && !complete_ack_reg;

  assign wd_active  = (state_reg != IDLE) && (state_reg != ERROR);
  assign wd_expired = (C_TIMEOUT != 0) && wd_active && (wd_cnt_reg == WD_W'(C_TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (pop) state_next = START;
      START:      if (job_accept) state_next = FETCH_WAIT;
                  else if (wd_expired) state_next = ERROR;
      FETCH_WAIT: if (job_fetch_request) state_next = DMA_REQ;
                  else if (wd_expired) state_next = ERROR;
      DMA_REQ:    if (dma_grant) state_next = DMA_WAIT;
                  else if (wd_expired) state_next = ERROR;
      DMA_WAIT:   if (dma_done) state_next = RUN;
                  else if (wd_expired) state_next = ERROR;
      RUN:        if (job_complete) state_next = IDLE;
                  else if (wd_expired) state_next = ERROR;
      ERROR:      if (err_clear) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    wd_cnt_next = '0;
    if (wd_active && (state_next == state_reg)) wd_cnt_next = wd_cnt_reg + 1'b1;
  end

  // Descriptor storage carries no reset so it maps onto plain memory.
  always_ff @(posedge clk_if) begin
    if (push) fifo_mem[wr_ptr_reg] <= desc_data;
  end

  always_ff @(posedge clk_if or negedge rst) begin
    if (!rst) begin
      state_reg          <= IDLE;
      wd_cnt_reg         <= '0;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
      job_parameters_reg <= '0;
      err_state_reg      <= '0;
      jobs_done_reg      <= '0;
      fetch_ack_reg      <= 1'b0;
      fetch_complete_reg <= 1'b0;
      complete_ack_reg   <= 1'b0;
    end else begin
      state_reg          <= state_next;
      wd_cnt_reg         <= wd_cnt_next;
      fetch_ack_reg      <= (state_reg == DMA_REQ) && dma_grant;
      fetch_complete_reg <= (state_reg == DMA_WAIT) && dma_done;
      complete_ack_reg   <= (state_reg == RUN) && job_complete;
      if ((state_next == ERROR) && (state_reg != ERROR)) err_state_reg <= state_reg;
      if ((state_reg == RUN) && job_complete) jobs_done_reg <= jobs_done_reg + 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg         <= rd_ptr_reg + 1'b1;
        job_parameters_reg <= fifo_mem[rd_ptr_reg];
      end
      if (push && !pop) count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  assign desc_ready         = !fifo_full;
  assign job_start          = (state_reg == START);
  assign job_parameters     = job_parameters_reg;
  assign job_fetch_ack      = fetch_ack_reg;
  assign job_fetch_complete = fetch_complete_reg;
  assign job_complete_ack   = complete_ack_reg;
  assign dma_req            = (state_reg == DMA_REQ);
  assign busy               = (state_reg != IDLE) || !fifo_empty;
  assign timeout_err        = (state_reg == ERROR);
  assign err_state          = err_state_reg;
  assign jobs_done          = jobs_done_reg;

endmodule

// File: tb/tb_cnn_layer_accel_job_sequencer.sv
// Directed bench for cnn_layer_accel_job_sequencer: a per-cycle vector table for one job,
// then hand sequences for FIFO full, back-to-back, timeout, timeout race and mid-job reset.
module tb_cnn_layer_accel_job_sequencer;

  localparam int CW = 16;
  localparam logic [127:0] DA5 = {16{8'hA5}};

  logic          clk_if = 1'b0;
  logic          rst;
  logic          desc_valid, desc_ready;
  logic [127:0]  desc_data;
  logic          job_start, job_accept;
  logic [127:0]  job_parameters;
  logic          job_fetch_request, job_fetch_ack, job_fetch_complete;
  logic          job_complete, job_complete_ack;
  logic          dma_req, dma_grant, dma_done, err_clear;
  logic          busy, timeout_err;
  logic [2:0]    err_state;
  logic [CW-1:0] jobs_done;

  int tests = 0;
  int failures = 0;

  cnn_layer_accel_job_sequencer #(
    .C_DESC_DEPTH(4),
    .C_TIMEOUT(16),
    .C_CNT_W(CW)
  ) dut (
    .clk_if(clk_if), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_data(desc_data),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete), .job_complete(job_complete),
    .job_complete_ack(job_complete_ack), .dma_req(dma_req), .dma_grant(dma_grant),
    .dma_done(dma_done), .err_clear(err_clear), .busy(busy), .timeout_err(timeout_err),
    .err_state(err_state), .jobs_done(jobs_done)
  );

  always #5 clk_if = ~clk_if;

  // in  = {desc_valid, job_accept, job_fetch_request, job_complete, dma_grant, dma_done, err_clear}
  // out = {desc_ready, job_start, fetch_ack, fetch_complete, complete_ack, dma_req, busy, timeout_err}
  typedef struct packed {
    logic [6:0]    in;
    logic [127:0]  data;
    logic [7:0]    exp_out;
    logic [CW-1:0] exp_done;
    logic [127:0]  exp_par;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_if);
    #1;
  endtask

  task automatic clear_inputs();
    desc_valid = 0; desc_data = '0; job_accept = 0; job_fetch_request = 0;
    job_complete = 0; dma_grant = 0; dma_done = 0; err_clear = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_desc_ready"}, desc_ready, 1);
    chk({tag, "_job_start"}, job_start, 0);
    chk({tag, "_params"}, job_parameters, 0);
    chk({tag, "_pulses"}, {job_fetch_ack, job_fetch_complete, job_complete_ack}, 0);
    chk({tag, "_dma_req"}, dma_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_err_state"}, err_state, 0);
    chk({tag, "_jobs_done"}, jobs_done, 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
    step();
  endtask

  task automatic push(input logic [127:0] d);
    desc_valid = 1; desc_data = d;
    step();
    desc_valid = 0;
  endtask

  task automatic wait_start(input int budget, input string tag);
    int n = 0;
    while (!job_start && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_start_seen"}, job_start, 1);
  endtask

  task automatic drive_to_run(input string tag, input logic [127:0] exp_data);
    wait_start(20, tag);
    chk({tag, "_params"}, job_parameters, exp_data);
    job_accept = 1; step(); job_accept = 0;
    chk({tag, "_start_drop"}, job_start, 0);
    job_fetch_request = 1; step(); job_fetch_request = 0;
    chk({tag, "_dma_req"}, dma_req, 1);
    dma_grant = 1; step(); dma_grant = 0;
    chk({tag, "_fetch_ack"}, job_fetch_ack, 1);
    chk({tag, "_dma_req_drop"}, dma_req, 0);
    dma_done = 1; step(); dma_done = 0;
    chk({tag, "_fetch_cmpl"}, job_fetch_complete, 1);
    chk({tag, "_fetch_ack_1cyc"}, job_fetch_ack, 0);
  endtask

  task automatic finish_job(input string tag);
    job_complete = 1; step(); job_complete = 0;
    chk({tag, "_cmpl_ack"}, job_complete_ack, 1);
    chk({tag, "_fetch_cmpl_1cyc"}, job_fetch_complete, 0);
    $display("[TB] job %s done, jobs_done=%0d", tag, jobs_done);
  endtask

  task automatic run_job(input string tag, input logic [127:0] exp_data);
    drive_to_run(tag, exp_data);
    finish_job(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [127:0] fd [5];
    logic [7:0]   act_out;

    vecs[0]  = '{7'b1000000, DA5,    8'b10000010, 16'd0, 128'd0};
    vecs[1]  = '{7'b0000000, 128'd0, 8'b11000010, 16'd0, DA5};
    vecs[2]  = '{7'b0000000, 128'd0, 8'b11000010, 16'd0, DA5};
    vecs[3]  = '{7'b0000000, 128'd0, 8'b11000010, 16'd0, DA5};
    vecs[4]  = '{7'b0100000, 128'd0, 8'b10000010, 16'd0, DA5};
    vecs[5]  = '{7'b0001110, 128'd0, 8'b10000010, 16'd0, DA5};
    vecs[6]  = '{7'b0010000, 128'd0, 8'b10000110, 16'd0, DA5};
    vecs[7]  = '{7'b0000000, 128'd0, 8'b10000110, 16'd0, DA5};
    vecs[8]  = '{7'b0000000, 128'd0, 8'b10000110, 16'd0, DA5};
    vecs[9]  = '{7'b0000100, 128'd0, 8'b10100010, 16'd0, DA5};
    vecs[10] = '{7'b0000010, 128'd0, 8'b10010010, 16'd0, DA5};
    vecs[11] = '{7'b0010100, 128'd0, 8'b10000010, 16'd0, DA5};
    vecs[12] = '{7'b0001000, 128'd0, 8'b10001000, 16'd1, DA5};
    vecs[13] = '{7'b0000000, 128'd0, 8'b10000000, 16'd1, DA5};

    for (int i = 0; i < 5; i++) fd[i] = {32'hD0D0_0000 + 32'(i), 32'h1111_1111, 32'h2222_2222, 32'h3000_0000 + 32'(i)};

    // Single job, cycle by cycle
    do_reset();
    check_reset_outputs("reset");
    for (int i = 0; i < 14; i++) begin
      {desc_valid, job_accept, job_fetch_request, job_complete, dma_grant, dma_done, err_clear} = vecs[i].in;
      desc_data = vecs[i].data;
      step();
      act_out = {desc_ready, job_start, job_fetch_ack, job_fetch_complete, job_complete_ack,
                 dma_req, busy, timeout_err};
      chk($sformatf("vec%0d_out", i), act_out, vecs[i].exp_out);
      chk($sformatf("vec%0d_jobs_done", i), jobs_done, vecs[i].exp_done);
      chk($sformatf("vec%0d_params", i), job_parameters, vecs[i].exp_par);
      $display("[TB] vec %0d in=%b out=%b jobs_done=%0d", i, vecs[i].in, act_out, jobs_done);
    end
    clear_inputs();

    // FIFO full while a job sits in RUN
    do_reset();
    push(DA5);
    drive_to_run("fifoA", DA5);
    for (int i = 0; i < 5; i++) begin
      desc_valid = 1; desc_data = fd[i];
      step();
      chk($sformatf("fifo_push%0d_ready", i), desc_ready, (i < 3) ? 1 : 0);
      $display("[TB] fifo push %0d desc_ready=%0d", i, desc_ready);
    end
    desc_valid = 0;
    finish_job("fifoA");
    for (int i = 0; i < 4; i++) run_job($sformatf("fifo%0d", i), fd[i]);
    step();
    step();
    chk("fifo_no_fifth_job", job_start, 0);
    chk("fifo_busy_end", busy, 0);
    chk("fifo_jobs_done", jobs_done, 5);

    // Back-to-back cadence
    do_reset();
    push(fd[0]);
    push(fd[1]);
    push(fd[2]);
    run_job("b2b0", fd[0]);
    for (int k = 1; k < 3; k++) begin
      step();
      chk($sformatf("b2b%0d_gap", k), job_start, 0);
      step();
      chk($sformatf("b2b%0d_start_at_2", k), job_start, 1);
      run_job($sformatf("b2b%0d", k), fd[k]);
    end
    chk("b2b_jobs_done", jobs_done, 3);

    // Timeout in DMA_REQ, then recovery
    do_reset();
    push(fd[1]);
    push(fd[2]);
    wait_start(20, "tmo");
    job_accept = 1; step(); job_accept = 0;
    job_fetch_request = 1; step(); job_fetch_request = 0;
    chk("tmo_in_dma_req", dma_req, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("tmo_c%0d_err", k), timeout_err, (k == 16) ? 1 : 0);
      chk($sformatf("tmo_c%0d_dma_req", k), dma_req, (k == 16) ? 0 : 1);
    end
    chk("tmo_err_state", err_state, 3);
    chk("tmo_job_start", job_start, 0);
    push(fd[3]);
    chk("tmo_push_in_error", desc_ready, 1);
    step();
    chk("tmo_hold_err", timeout_err, 1);
    chk("tmo_no_pop", job_start, 0);
    err_clear = 1; step(); err_clear = 0;
    chk("tmo_clear_err", timeout_err, 0);
    chk("tmo_err_state_kept", err_state, 3);
    run_job("tmo_next", fd[2]);
    run_job("tmo_pushed", fd[3]);
    $display("[TB] timeout recovered, jobs_done=%0d", jobs_done);

    // dma_done on the watchdog's last cycle
    do_reset();
    push(fd[4]);
    wait_start(20, "race");
    job_accept = 1; step(); job_accept = 0;
    job_fetch_request = 1; step(); job_fetch_request = 0;
    dma_grant = 1; step(); dma_grant = 0;
    repeat (15) step();
    chk("race_before_err", timeout_err, 0);
    dma_done = 1; step(); dma_done = 0;
    chk("race_fetch_cmpl", job_fetch_complete, 1);
    chk("race_no_err", timeout_err, 0);
    chk("race_err_state", err_state, 0);
    finish_job("race");
    chk("race_jobs_done", jobs_done, 1);

    // Reset during RUN with two descriptors queued
    do_reset();
    push(fd[0]);
    push(fd[1]);
    push(fd[2]);
    push(fd[3]);
    run_job("rst0", fd[0]);
    drive_to_run("rst1", fd[1]);
    chk("rst_busy_before", busy, 1);
    rst = 0;
    #1;
    check_reset_outputs("rst_mid");
    step();
    rst = 1;
    repeat (3) step();
    chk("rst_after_busy", busy, 0);
    chk("rst_after_start", job_start, 0);
    $display("[TB] mid-run reset done");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
